// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decode-stage immediate generator with a 2-entry output buffer.
// Decodes the immediate and format of one instruction per handshake and
// precomputes pc + imm. Results sit in a small FIFO, so in_ready depends only
// on registered occupancy and never on out_ready.
module imm_gen_pipe #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ZIMM_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            unknown,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] tgt
);

  typedef logic [XLEN-1:0] xlen_t;

  typedef enum logic [2:0] {
    FmtI    = 3'd0,
    FmtS    = 3'd1,
    FmtB    = 3'd2,
    FmtU    = 3'd3,
    FmtJ    = 3'd4,
    FmtZ    = 3'd5,
    FmtNone = 3'd7
  } fmt_e;

  // One buffered decode result
  typedef struct packed {
    xlen_t imm;
    xlen_t pc;
    xlen_t tgt;
    fmt_e  fmt;
    logic  unknown;
  } entry_t;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpImm32  = 7'b0011011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam bit Rv64    = (XLEN == 64);
  localparam bit ZimmDec = (ZIMM_EN != 0);

  // ---------------------------------------------------------------------------
  // Immediate decode
  // ---------------------------------------------------------------------------
  logic [6:0]  opcode;
  logic [11:0] i_field;
  logic [11:0] s_field;
  logic [12:0] b_field;
  logic [31:0] u_field;
  logic [20:0] j_field;
  logic [4:0]  z_field;

  assign opcode  = instr[6:0];
  assign i_field = instr[31:20];
  assign s_field = {instr[31:25], instr[11:7]};
  assign b_field = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign u_field = {instr[31:12], 12'b0};
  assign j_field = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign z_field = instr[19:15];

  xlen_t dec_imm;
  fmt_e  dec_fmt;
  logic  dec_unknown;
  xlen_t dec_tgt;

  // Select the format from the opcode; every path assigns all decode outputs
  always_comb begin
    dec_imm     = '0;
    dec_fmt     = FmtNone;
    dec_unknown = 1'b1;
    unique case (opcode)
      OpLoad, OpImm, OpJalr: begin
        dec_imm     = xlen_t'($signed(i_field));
        dec_fmt     = FmtI;
        dec_unknown = 1'b0;
      end
      OpImm32: begin
        // OP-IMM-32 only exists on RV64
        if (Rv64) begin
          dec_imm     = xlen_t'($signed(i_field));
          dec_fmt     = FmtI;
          dec_unknown = 1'b0;
        end
      end
      OpStore: begin
        dec_imm     = xlen_t'($signed(s_field));
        dec_fmt     = FmtS;
        dec_unknown = 1'b0;
      end
      OpBranch: begin
        dec_imm     = xlen_t'($signed(b_field));
        dec_fmt     = FmtB;
        dec_unknown = 1'b0;
      end
      OpLui, OpAuipc: begin
        dec_imm     = xlen_t'($signed(u_field));
        dec_fmt     = FmtU;
        dec_unknown = 1'b0;
      end
      OpJal: begin
        dec_imm     = xlen_t'($signed(j_field));
        dec_fmt     = FmtJ;
        dec_unknown = 1'b0;
      end
      OpSystem: begin
        // funct3[2] set marks the CSR immediate forms (csrrwi/csrrsi/csrrci)
        if (ZimmDec && instr[14]) begin
          dec_imm = xlen_t'(z_field);
          dec_fmt = FmtZ;
        end else begin
          dec_imm = xlen_t'($signed(i_field));
          dec_fmt = FmtI;
        end
        dec_unknown = 1'b0;
      end
      default: begin
        dec_imm     = '0;
        dec_fmt     = FmtNone;
        dec_unknown = 1'b1;
      end
    endcase
  end

  // PC-relative target wraps naturally at XLEN bits
  assign dec_tgt = pc + dec_imm;

  // ---------------------------------------------------------------------------
  // Two-entry buffer
  // ---------------------------------------------------------------------------
  entry_t     mem_q [2];
  logic [1:0] count_q, count_d;
  logic       wptr_q, wptr_d;
  logic       rptr_q, rptr_d;
  logic       push;
  logic       pop;
  entry_t     new_entry;
  entry_t     rst_entry;
  entry_t     head;

  assign in_ready  = (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign new_entry = '{imm: dec_imm, pc: pc, tgt: dec_tgt, fmt: dec_fmt, unknown: dec_unknown};
  assign rst_entry = '{imm: '0, pc: '0, tgt: '0, fmt: FmtNone, unknown: 1'b0};

  // Pointer and occupancy update; flush wins over any push or pop
  always_comb begin
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (flush) begin
      count_d = 2'd0;
      wptr_d  = 1'b0;
      rptr_d  = 1'b0;
    end else begin
      if (push) begin
        wptr_d = ~wptr_q;
      end
      if (pop) begin
        rptr_d = ~rptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 2'd0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  // Entry storage; reset contents define the outputs seen right after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= rst_entry;
      end
    end else if (push && !flush) begin
      mem_q[wptr_q] <= new_entry;
    end
  end

  // Outputs are a direct read of the head entry
  assign head    = mem_q[rptr_q];
  assign imm     = head.imm;
  assign fmt     = head.fmt;
  assign unknown = head.unknown;
  assign pc_o    = head.pc;
  assign tgt     = head.tgt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three instances (RV32 with CSR immediates, RV64,
// RV32 without CSR immediates) share one stimulus stream. Directed vectors
// carry hand-computed results; the random phase uses an arithmetic model and
// a queue per instance.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [63:0] pc64;

  logic        a_in_ready, a_out_valid, a_unknown;
  logic [31:0] a_imm, a_pc_o, a_tgt;
  logic [2:0]  a_fmt;
  logic        b_in_ready, b_out_valid, b_unknown;
  logic [63:0] b_imm, b_pc_o, b_tgt;
  logic [2:0]  b_fmt;
  logic        c_in_ready, c_out_valid, c_unknown;
  logic [31:0] c_imm, c_pc_o, c_tgt;
  logic [2:0]  c_fmt;

  imm_gen_pipe #(.XLEN(32), .ZIMM_EN(1)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .instr(instr), .pc(pc64[31:0]), .out_valid(a_out_valid), .out_ready(out_ready),
    .imm(a_imm), .fmt(a_fmt), .unknown(a_unknown), .pc_o(a_pc_o), .tgt(a_tgt)
  );
  imm_gen_pipe #(.XLEN(64), .ZIMM_EN(1)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .instr(instr), .pc(pc64), .out_valid(b_out_valid), .out_ready(out_ready),
    .imm(b_imm), .fmt(b_fmt), .unknown(b_unknown), .pc_o(b_pc_o), .tgt(b_tgt)
  );
  imm_gen_pipe #(.XLEN(32), .ZIMM_EN(0)) dut_c (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
    .instr(instr), .pc(pc64[31:0]), .out_valid(c_out_valid), .out_ready(out_ready),
    .imm(c_imm), .fmt(c_fmt), .unknown(c_unknown), .pc_o(c_pc_o), .tgt(c_tgt)
  );

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        unk;
    logic [63:0] pc;
    logic [63:0] tgt;
  } res_t;

  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] ins;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        unk;
    logic [63:0] tgt;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Head outputs of one instance, widened to 64 bits
  task automatic read_out(input int sel, output res_t r, output logic v, output logic rdy);
    case (sel)
      1: begin
        r.imm = b_imm; r.fmt = b_fmt; r.unk = b_unknown; r.pc = b_pc_o; r.tgt = b_tgt;
        v = b_out_valid; rdy = b_in_ready;
      end
      2: begin
        r.imm = {32'b0, c_imm}; r.fmt = c_fmt; r.unk = c_unknown;
        r.pc = {32'b0, c_pc_o}; r.tgt = {32'b0, c_tgt};
        v = c_out_valid; rdy = c_in_ready;
      end
      default: begin
        r.imm = {32'b0, a_imm}; r.fmt = a_fmt; r.unk = a_unknown;
        r.pc = {32'b0, a_pc_o}; r.tgt = {32'b0, a_tgt};
        v = a_out_valid; rdy = a_in_ready;
      end
    endcase
  endtask

  task automatic chk_head(input string tag, input int sel, input res_t e);
    res_t r;
    logic v, rdy;
    read_out(sel, r, v, rdy);
    chk({tag, ".valid"}, v, 1'b1);
    chk({tag, ".imm"}, r.imm, e.imm);
    chk({tag, ".fmt"}, r.fmt, e.fmt);
    chk({tag, ".unknown"}, r.unk, e.unk);
    chk({tag, ".pc_o"}, r.pc, e.pc);
    chk({tag, ".tgt"}, r.tgt, e.tgt);
  endtask

  task automatic chk_reset(input string tag, input int sel);
    res_t r;
    logic v, rdy;
    read_out(sel, r, v, rdy);
    chk({tag, ".in_ready"}, rdy, 1'b1);
    chk({tag, ".out_valid"}, v, 1'b0);
    chk({tag, ".imm"}, r.imm, 64'h0);
    chk({tag, ".fmt"}, r.fmt, 3'd7);
    chk({tag, ".unknown"}, r.unk, 1'b0);
    chk({tag, ".pc_o"}, r.pc, 64'h0);
    chk({tag, ".tgt"}, r.tgt, 64'h0);
  endtask

  // Reference decode from field arithmetic on a sign-extended 64-bit word
  function automatic res_t model(input logic [31:0] ins, input logic [63:0] pc,
                                 input int xlen, input bit zimm);
    res_t        r;
    longint      sx;
    longint      v;
    logic [63:0] mask;
    sx    = longint'($signed(ins));
    v     = 0;
    r.fmt = 3'd7;
    case (ins[6:0])
      7'h03, 7'h13, 7'h67: begin r.fmt = 3'd0; v = sx >>> 20; end
      7'h1B: if (xlen == 64) begin r.fmt = 3'd0; v = sx >>> 20; end
      7'h23: begin r.fmt = 3'd1; v = ((sx >>> 25) <<< 5) | longint'(ins[11:7]); end
      7'h63: begin
        r.fmt = 3'd2;
        v = ((sx >>> 31) <<< 12) | (longint'(ins[7]) <<< 11) |
            (longint'(ins[30:25]) <<< 5) | (longint'(ins[11:8]) <<< 1);
      end
      7'h37, 7'h17: begin r.fmt = 3'd3; v = (sx >>> 12) <<< 12; end
      7'h6F: begin
        r.fmt = 3'd4;
        v = ((sx >>> 31) <<< 20) | (longint'(ins[19:12]) <<< 12) |
            (longint'(ins[20]) <<< 11) | (longint'(ins[30:21]) <<< 1);
      end
      7'h73: begin
        if (zimm && ins[14]) begin r.fmt = 3'd5; v = longint'(ins[19:15]); end
        else begin r.fmt = 3'd0; v = sx >>> 20; end
      end
      default: v = 0;
    endcase
    r.unk = (r.fmt == 3'd7);
    mask  = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    r.imm = v & mask;
    r.pc  = pc & mask;
    r.tgt = (pc + v) & mask;
    return r;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [11];
    logic [31:0] w;
    ops = '{7'h03, 7'h13, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h33};
    w = $urandom();
    if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 10)];
    return w;
  endfunction

  vec_t vecs [13];
  res_t qa[$], qb[$], qc[$];

  initial begin
    res_t e;
    vecs[0]  = '{2'd0, 32'hFFF00093, 64'h0, 64'hFFFFFFFF, 3'd0, 1'b0, 64'hFFFFFFFF};
    vecs[1]  = '{2'd0, 32'hFE20AE23, 64'h0, 64'hFFFFFFFC, 3'd1, 1'b0, 64'hFFFFFFFC};
    vecs[2]  = '{2'd0, 32'hFE000CE3, 64'h100, 64'hFFFFFFF8, 3'd2, 1'b0, 64'hF8};
    vecs[3]  = '{2'd0, 32'h001000EF, 64'h1000, 64'h800, 3'd4, 1'b0, 64'h1800};
    vecs[4]  = '{2'd0, 32'h0080006F, 64'hFFFFFFFC, 64'h8, 3'd4, 1'b0, 64'h4};
    vecs[5]  = '{2'd1, 32'h800002B7, 64'h0, 64'hFFFFFFFF80000000, 3'd3, 1'b0,
                 64'hFFFFFFFF80000000};
    vecs[6]  = '{2'd1, 32'h0010009B, 64'h0, 64'h1, 3'd0, 1'b0, 64'h1};
    vecs[7]  = '{2'd0, 32'h0010009B, 64'h0, 64'h0, 3'd7, 1'b1, 64'h0};
    vecs[8]  = '{2'd0, 32'h300FD073, 64'h0, 64'h1F, 3'd5, 1'b0, 64'h1F};
    vecs[9]  = '{2'd2, 32'h300FD073, 64'h0, 64'h300, 3'd0, 1'b0, 64'h300};
    vecs[10] = '{2'd0, 32'h00000033, 64'h40, 64'h0, 3'd7, 1'b1, 64'h40};
    vecs[11] = '{2'd1, 32'hFE000CE3, 64'h100, 64'hFFFFFFFFFFFFFFF8, 3'd2, 1'b0, 64'hF8};
    vecs[12] = '{2'd1, 32'h0080006F, 64'hFFFFFFFC, 64'h8, 3'd4, 1'b0, 64'h1_00000004};

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = 32'h0; pc64 = 64'h0;
    #1 rst = 1'b1;
    #2;
    chk_reset("reset_a", 0);
    chk_reset("reset_b", 1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors streamed back-to-back, each visible one edge after push
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      instr = vecs[i].ins; pc64 = vecs[i].pc; in_valid = 1'b1;
      @(posedge clk); #1;
      e.imm = vecs[i].imm; e.fmt = vecs[i].fmt; e.unk = vecs[i].unk;
      e.pc = vecs[i].pc; e.tgt = vecs[i].tgt;
      chk_head($sformatf("vec%0d", i), int'(vecs[i].sel), e);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain.out_valid", a_out_valid, 1'b0);

    // Backpressure: third instruction waits until a slot frees up
    out_ready = 1'b0; pc64 = 64'h0; in_valid = 1'b1;
    instr = 32'h00100093;
    @(posedge clk); #1;
    chk("bp.ready_after_1", a_in_ready, 1'b1);
    instr = 32'h00200093;
    @(posedge clk); #1;
    chk("bp.ready_after_2", a_in_ready, 1'b0);
    instr = 32'h00300093;
    @(posedge clk); #1;
    chk("bp.ready_held", a_in_ready, 1'b0);
    chk("bp.head_first", {32'b0, a_imm}, 64'h1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.head_second", {32'b0, a_imm}, 64'h2);
    chk("bp.ready_after_pop", a_in_ready, 1'b1);
    @(posedge clk); #1;
    chk("bp.head_third", {32'b0, a_imm}, 64'h3);
    chk("bp.valid_third", a_out_valid, 1'b1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp.empty", a_out_valid, 1'b0);

    // Flush with a simultaneous push on a full buffer
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00400093;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("fl.full", a_in_ready, 1'b0);
    flush = 1'b1; instr = 32'h00700093;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("fl.out_valid", a_out_valid, 1'b0);
    chk("fl.in_ready", a_in_ready, 1'b1);
    @(posedge clk); #1;
    chk("fl.not_stored", a_out_valid, 1'b0);

    // Asynchronous reset mid-stream
    in_valid = 1'b1; instr = 32'h00500093; pc64 = 64'h20;
    @(posedge clk); #1;
    instr = 32'hFE000CE3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mr.full", a_in_ready, 1'b0);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk_reset("midrst_a", 0);
    chk_reset("midrst_b", 1);
    @(negedge clk) rst = 1'b0;

    // Random traffic against the queue model
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit do_push, do_pop;
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      instr     = rand_instr();
      pc64      = {$urandom(), $urandom()};
      #1;
      chk("rnd.in_ready", a_in_ready, (qa.size() < 2));
      chk("rnd.out_valid", a_out_valid, (qa.size() != 0));
      if (qa.size() != 0) begin
        chk_head("rnd_a", 0, qa[0]);
        chk_head("rnd_b", 1, qb[0]);
        chk_head("rnd_c", 2, qc[0]);
      end
      do_push = in_valid && (qa.size() < 2);
      do_pop  = out_ready && (qa.size() != 0);
      if (flush) begin
        qa.delete(); qb.delete(); qc.delete();
      end else begin
        if (do_pop) begin
          void'(qa.pop_front()); void'(qb.pop_front()); void'(qc.pop_front());
        end
        if (do_push) begin
          qa.push_back(model(instr, pc64, 32, 1'b1));
          qb.push_back(model(instr, pc64, 64, 1'b1));
          qc.push_back(model(instr, pc64, 32, 1'b0));
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
